// File: rtl/alien_shot_scheduler.sv
// alien_shot_scheduler: picks when and from which alien column the next bomb drops.
// Pulses the random block, walks columns from the random start until a live one
// is found, then holds a req/ack fire request to the bomb-spawn logic.
// Rate-limited by a per-frame cooldown and a cap on bombs in flight.
// Optional feature macro: SHOT_SCHED_AIM_EN (aimed shots start at player_col).
module alien_shot_scheduler #(
  parameter int COL_BITS  = 3,
  parameter int RAND_BITS = 8,
  parameter int COOLDOWN  = 50,
  parameter int MAX_SHOTS = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       startOfFrame,
  input  logic [RAND_BITS-1:0]       rand_val,
  input  logic [(1<<COL_BITS)-1:0]   alive_cols,
`ifdef SHOT_SCHED_AIM_EN
  input  logic [COL_BITS-1:0]        player_col,
`endif
  input  logic                       shot_done,
  input  logic                       fire_ack,
  output logic                       rand_rise,
  output logic                       fire_req,
  output logic [COL_BITS-1:0]        fire_col,
  output logic [2:0]                 shots_active
);

  localparam logic [7:0]        CD_RELOAD = 8'(COOLDOWN);
  localparam logic [2:0]        MAX_Q     = 3'(MAX_SHOTS);
  localparam logic [COL_BITS:0] LAST_CNT  = {1'b0, {COL_BITS{1'b1}}};

  typedef enum logic [2:0] {IDLE, RISE, WAIT, SEARCH, REQ} state_t;

  state_t                state_q, state_d;
  logic [7:0]            cool_q, cool_d;
  logic                  rand_rise_q;
  logic                  fire_req_q, fire_req_d;
  logic [COL_BITS-1:0]   fire_col_q, fire_col_d;
  logic [2:0]            shots_q, shots_d;
  logic [COL_BITS-1:0]   scan_col_q, scan_col_d;
  logic [COL_BITS:0]     scan_cnt_q, scan_cnt_d;
  logic [COL_BITS-1:0]   start_col;
  logic                  shot_inc, shot_dec;

  // Only the low column bits (and the aim flag) of the random value matter.
  logic unused_rand_bits;
  assign unused_rand_bits = ^rand_val[RAND_BITS-1:COL_BITS];

  // Search start column: random, or the player's column for an aimed shot.
`ifdef SHOT_SCHED_AIM_EN
  assign start_col = rand_val[RAND_BITS-1] ? player_col : rand_val[COL_BITS-1:0];
`else
  assign start_col = rand_val[COL_BITS-1:0];
`endif

  // Next-state logic for the shot FSM, cooldown and column search.
  always_comb begin
    state_d    = state_q;
    cool_d     = cool_q;
    fire_req_d = fire_req_q;
    fire_col_d = fire_col_q;
    scan_col_d = scan_col_q;
    scan_cnt_d = scan_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (startOfFrame && cool_q != 8'd0) cool_d = cool_q - 8'd1;
        if (cool_q == 8'd0 && shots_q < MAX_Q) state_d = RISE;
      end
      RISE: state_d = WAIT;
      WAIT: begin
        scan_col_d = start_col;
        scan_cnt_d = '0;
        state_d    = SEARCH;
      end
      SEARCH: begin
        if (alive_cols[scan_col_q]) begin
          fire_col_d = scan_col_q;
          fire_req_d = 1'b1;
          state_d    = REQ;
        end else begin
          scan_col_d = scan_col_q + 1'b1;
          scan_cnt_d = scan_cnt_q + 1'b1;
          // Every column visited with nothing alive: give up this attempt.
          if (scan_cnt_q == LAST_CNT) begin
            cool_d  = CD_RELOAD;
            state_d = IDLE;
          end
        end
      end
      REQ: begin
        if (fire_ack) begin
          fire_req_d = 1'b0;
          cool_d     = CD_RELOAD;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bombs-in-flight counter: ack adds, shot_done removes, both cancel out.
  assign shot_inc = (state_q == REQ) && fire_ack;
  assign shot_dec = shot_done && (shots_q != 3'd0);
  always_comb begin
    shots_d = shots_q;
    if (shot_inc && !shot_dec && shots_q < MAX_Q) shots_d = shots_q + 3'd1;
    else if (shot_dec && !shot_inc)                 shots_d = shots_q - 3'd1;
  end

  // State registers; rand_rise is the registered image of the RISE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cool_q      <= CD_RELOAD;
      rand_rise_q <= 1'b0;
      fire_req_q  <= 1'b0;
      fire_col_q  <= '0;
      shots_q     <= 3'd0;
      scan_col_q  <= '0;
      scan_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cool_q      <= cool_d;
      rand_rise_q <= (state_q == RISE);
      fire_req_q  <= fire_req_d;
      fire_col_q  <= fire_col_d;
      shots_q     <= shots_d;
      scan_col_q  <= scan_col_d;
      scan_cnt_q  <= scan_cnt_d;
    end
  end

  assign rand_rise    = rand_rise_q;
  assign fire_req     = fire_req_q;
  assign fire_col     = fire_col_q;
  assign shots_active = shots_q;

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// Directed bench for alien_shot_scheduler: a table of search vectors plus
// hand-written sequences for the shot cap, held requests, reset and counting.
module tb_alien_shot_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       startOfFrame;
  logic [7:0] rand_val;
  logic [7:0] alive_cols;
  logic [2:0] player_col;
  logic       shot_done;
  logic       fire_ack;
  logic       rand_rise;
  logic       fire_req;
  logic [2:0] fire_col;
  logic [2:0] shots_active;

  int checks = 0;
  int errors = 0;
  int exp_shots = 0;

  alien_shot_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (startOfFrame),
    .rand_val     (rand_val),
    .alive_cols   (alive_cols),
`ifdef SHOT_SCHED_AIM_EN
    .player_col   (player_col),
`endif
    .shot_done    (shot_done),
    .fire_ack     (fire_ack),
    .rand_rise    (rand_rise),
    .fire_req     (fire_req),
    .fire_col     (fire_col),
    .shots_active (shots_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rv;
    logic [7:0] alive;
    bit         fire;
    int         col;
    int         dly;   // cycles from rand_rise to fire_req
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // n frame pulses on alternate cycles; reports whether rand_rise was seen.
  task automatic frames(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1; tick(); seen |= rand_rise;
      startOfFrame = 1'b0; tick(); seen |= rand_rise;
    end
  endtask

  // mode 0: ack only, 1: ack then shot_done, 2: ack together with shot_done,
  // 3: no ack (leave the request pending).
  task automatic run_vec(input vec_t v, input int mode, input string tag);
    bit seen;
    int n;
    int m;
    rand_val   = v.rv;
    alive_cols = v.alive;
    frames(49, seen);
    chk({tag, "_no_early_rise"}, int'(seen), 0);
    frames(1, seen);
    chk({tag, "_no_rise_at_last_frame"}, int'(seen), 0);
    n = 0;
    while (!rand_rise && n < 10) begin tick(); n++; end
    chk({tag, "_rise_latency"}, n, 1);
    tick();
    chk({tag, "_rise_width"}, int'(rand_rise), 0);
    m = 1;
    while (!fire_req && m < 12) begin tick(); m++; end
    if (!v.fire) begin
      chk({tag, "_no_fire"}, int'(fire_req), 0);
      return;
    end
    chk({tag, "_fire_delay"}, m, v.dly);
    chk({tag, "_fire_col"}, int'(fire_col), v.col);
    if (mode == 3) return;
    fire_ack  = 1'b1;
    shot_done = (mode == 2);
    tick();
    fire_ack  = 1'b0;
    shot_done = 1'b0;
    if (mode != 2) exp_shots++;
    chk({tag, "_req_dropped"}, int'(fire_req), 0);
    chk({tag, "_shots_after_ack"}, int'(shots_active), exp_shots);
    if (mode == 1) begin
      shot_done = 1'b1; tick(); shot_done = 1'b0;
      exp_shots--;
      chk({tag, "_shots_after_done"}, int'(shots_active), exp_shots);
    end
  endtask

  initial begin
    bit seen;
    bit stable;
    int m;
    vec_t v;

    tbl[0] = '{rv: 8'h05, alive: 8'hFF, fire: 1'b1, col: 5, dly: 2};
    tbl[1] = '{rv: 8'h06, alive: 8'h03, fire: 1'b1, col: 0, dly: 4};
    tbl[2] = '{rv: 8'h00, alive: 8'h00, fire: 1'b0, col: 0, dly: 0};
    tbl[3] = '{rv: 8'h07, alive: 8'h01, fire: 1'b1, col: 0, dly: 3};
    tbl[4] = '{rv: 8'h7A, alive: 8'h04, fire: 1'b1, col: 2, dly: 2};
    tbl[5] = '{rv: 8'h03, alive: 8'h80, fire: 1'b1, col: 7, dly: 6};

    reset = 1'b1; startOfFrame = 1'b0; rand_val = 8'h00; alive_cols = 8'hFF;
    player_col = 3'd0; shot_done = 1'b0; fire_ack = 1'b0;
    tick(); tick();
    chk("reset_rand_rise", int'(rand_rise), 0);
    chk("reset_fire_req", int'(fire_req), 0);
    chk("reset_fire_col", int'(fire_col), 0);
    chk("reset_shots", int'(shots_active), 0);
    reset = 1'b0;
    tick();

    // Search vectors; the empty-field vector also proves the cooldown reload,
    // since the following vector checks no rise within 49 frames.
    for (int i = 0; i < 6; i++) run_vec(tbl[i], 1, $sformatf("vec%0d", i));

    // Cap on bombs in flight.
    v = tbl[0];
    run_vec(v, 0, "cap1");
    run_vec(v, 0, "cap2");
    run_vec(v, 0, "cap3");
    chk("cap_shots_3", int'(shots_active), 3);
    frames(60, seen);
    chk("cap_no_rise", int'(seen), 0);
    shot_done = 1'b1; tick(); shot_done = 1'b0;
    exp_shots--;
    chk("cap_shots_2", int'(shots_active), 2);
    tick();
    chk("cap_rise_not_yet", int'(rand_rise), 0);
    tick();
    chk("cap_rise_after_done", int'(rand_rise), 1);

    // Request held while ack stays low; dead column does not drop it.
    tick();
    m = 1;
    while (!fire_req && m < 12) begin tick(); m++; end
    chk("hold_fire_delay", m, 2);
    chk("hold_fire_col", int'(fire_col), 5);
    alive_cols = 8'h00;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      startOfFrame = i[0];
      tick();
      if (!fire_req || fire_col != 3'd5) stable = 1'b0;
    end
    startOfFrame = 1'b0;
    chk("hold_stable", int'(stable), 1);

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1'b1;
    #1;
    chk("async_rst_fire_req", int'(fire_req), 0);
    chk("async_rst_fire_col", int'(fire_col), 0);
    chk("async_rst_shots", int'(shots_active), 0);
    chk("async_rst_rise", int'(rand_rise), 0);
    tick();
    reset = 1'b0;
    exp_shots = 0;
    tick();

    // Simultaneous ack and shot_done leave the count unchanged.
    run_vec(v, 0, "net1");
    run_vec(v, 2, "net2");
    chk("net_shots_1", int'(shots_active), 1);
    shot_done = 1'b1; tick(); shot_done = 1'b0;
    chk("done_to_0", int'(shots_active), 0);
    shot_done = 1'b1; tick(); shot_done = 1'b0;
    chk("done_sat_0", int'(shots_active), 0);
    fire_ack = 1'b1; tick(); fire_ack = 1'b0;
    chk("stray_ack_ignored", int'(shots_active), 0);
    exp_shots = 0;

`ifdef SHOT_SCHED_AIM_EN
    player_col = 3'd2;
    v = '{rv: 8'h80, alive: 8'hFF, fire: 1'b1, col: 2, dly: 2};
    run_vec(v, 1, "aim");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
